// File: rtl/sipo_frame_ctrl.sv
// Framed serial-to-parallel receiver: start-bit detect, WIDTH-bit shift, valid/ready output holding register.
// Optional even-parity bit after the data bits is compiled in with `define SIPO_FRAME_CTRL_PARITY_EN.
module sipo_frame_ctrl #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             sin,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic             busy,
    output logic             overrun,
    output logic             parity_err,
    input  logic             clr_flags,
    output logic [CNT_W-1:0] word_cnt
);

    localparam int BC_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [BC_W-1:0] LAST_BIT = BC_W'(WIDTH - 1);

`ifdef SIPO_FRAME_CTRL_PARITY_EN
    typedef enum logic [1:0] {IDLE, SHIFT, PAR} state_t;
`else
    typedef enum logic [0:0] {IDLE, SHIFT} state_t;
`endif

    state_t          state;
    logic [WIDTH-1:0] sr;
    logic [BC_W-1:0]  bit_cnt;

    logic             load_evt;
    logic [WIDTH-1:0] load_word;
    logic             par_bad;
    logic             load_ok;
    logic             accept;

    always_comb begin
        load_evt  = 1'b0;
        load_word = sr;
        par_bad   = 1'b0;
`ifdef SIPO_FRAME_CTRL_PARITY_EN
        // sr already holds the full word here; the parity bit is on sin.
        if (state == PAR) begin
            if ((^sr) ^ sin) par_bad = 1'b1;
            else             load_evt = 1'b1;
        end
`else
        if (state == SHIFT && bit_cnt == LAST_BIT) begin
            load_evt  = 1'b1;
            load_word = {sr[WIDTH-2:0], sin};
        end
`endif
    end

    assign load_ok = !dout_valid || dout_ready;
    assign accept  = dout_valid && dout_ready;
    assign busy    = (state != IDLE);

    // NOTE: all state below updates with non-blocking assignments so every
    // branch sees the pre-edge values of state, sr and dout_valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            sr         <= '0;
            bit_cnt    <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
            overrun    <= 1'b0;
            word_cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    bit_cnt <= '0;
                    if (en && sin) state <= SHIFT;
                end
                SHIFT: begin
                    sr <= {sr[WIDTH-2:0], sin};
                    if (bit_cnt == LAST_BIT) begin
                        bit_cnt <= '0;
`ifdef SIPO_FRAME_CTRL_PARITY_EN
                        state   <= PAR;
`else
                        state   <= IDLE;
`endif
                    end else begin
                        bit_cnt <= bit_cnt + BC_W'(1);
                    end
                end
`ifdef SIPO_FRAME_CTRL_PARITY_EN
                PAR:     state <= IDLE;
`endif
                default: state <= IDLE;
            endcase

            // A load in the same cycle as an accept keeps dout_valid high with the new word.
            if (load_evt && load_ok) begin
                dout       <= load_word;
                dout_valid <= 1'b1;
                word_cnt   <= word_cnt + CNT_W'(1);
            end else if (accept) begin
                dout_valid <= 1'b0;
            end

            // Set has priority over clear for the sticky flags.
            if (load_evt && !load_ok) overrun <= 1'b1;
            else if (clr_flags)       overrun <= 1'b0;
        end
    end

`ifdef SIPO_FRAME_CTRL_PARITY_EN
    always_ff @(posedge clk) begin
        if (rst)            parity_err <= 1'b0;
        else if (par_bad)   parity_err <= 1'b1;
        else if (clr_flags) parity_err <= 1'b0;
    end
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_sipo_frame_ctrl.sv
// Directed bench for sipo_frame_ctrl (WIDTH=4, CNT_W=8): vector table plus hand-written frame sequences.
// Parity-specific sequences run when SIPO_FRAME_CTRL_PARITY_EN is defined.
module tb_sipo_frame_ctrl;

    localparam int WIDTH = 4;
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst, en, sin, dout_ready, clr_flags;
    logic [WIDTH-1:0] dout;
    logic             dout_valid, busy, overrun, parity_err;
    logic [CNT_W-1:0] word_cnt;

    int n_cmp  = 0;
    int n_fail = 0;

    sipo_frame_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .sin        (sin),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .busy       (busy),
        .overrun    (overrun),
        .parity_err (parity_err),
        .clr_flags  (clr_flags),
        .word_cnt   (word_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic             rst, en, sin, rdy, clr;
        logic             e_valid;
        logic [WIDTH-1:0] e_dout;
        logic             e_busy, e_ov;
        logic [CNT_W-1:0] e_cnt;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Inputs are driven at the falling edge; outputs are read at the next falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic add(input logic r, e, s, rd, c, ev, input logic [3:0] ed,
                       input logic eb, eo, input logic [7:0] ec);
        vec_t v;
        v.rst = r; v.en = e; v.sin = s; v.rdy = rd; v.clr = c;
        v.e_valid = ev; v.e_dout = ed; v.e_busy = eb; v.e_ov = eo; v.e_cnt = ec;
        tbl.push_back(v);
    endtask

    task automatic check_all(input string tag, input logic ev, input logic [3:0] ed,
                             input logic eb, input logic eo, input logic [7:0] ec);
        check({tag, " valid"},   32'(dout_valid), 32'(ev));
        check({tag, " dout"},    32'(dout),       32'(ed));
        check({tag, " busy"},    32'(busy),       32'(eb));
        check({tag, " overrun"}, 32'(overrun),    32'(eo));
        check({tag, " cnt"},     32'(word_cnt),   32'(ec));
    endtask

    // Start bit, WIDTH data bits MSB first, then the parity bit in the parity build.
    task automatic send_frame(input logic [3:0] w, input logic rdy, input logic par_ok);
        en = 1'b1; sin = 1'b1; dout_ready = rdy;
        tick();
        en = 1'b0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            sin = w[i];
            tick();
        end
`ifdef SIPO_FRAME_CTRL_PARITY_EN
        sin = (^w) ^ ~par_ok;
        tick();
`else
        if (par_ok !== 1'b1) $display("note: parity request ignored in this build");
`endif
        sin = 1'b0;
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; sin = 1'b0; dout_ready = 1'b0; clr_flags = 1'b0;
        @(negedge clk);

`ifndef SIPO_FRAME_CTRL_PARITY_EN
        //   rst en sin rdy clr | valid dout   busy ov cnt
        add(1, 0, 0, 0, 0,   0, 4'b0000, 0, 0, 0);
        add(0, 1, 1, 0, 0,   0, 4'b0000, 1, 0, 0);   // frame 1011, hold ready low
        add(0, 1, 1, 0, 0,   0, 4'b0000, 1, 0, 0);
        add(0, 1, 0, 0, 0,   0, 4'b0000, 1, 0, 0);
        add(0, 1, 1, 0, 0,   0, 4'b0000, 1, 0, 0);
        add(0, 1, 1, 0, 0,   1, 4'b1011, 0, 0, 1);
        add(0, 1, 0, 0, 0,   1, 4'b1011, 0, 0, 1);
        add(0, 1, 0, 1, 0,   0, 4'b1011, 0, 0, 1);   // accepted
        add(0, 1, 1, 0, 0,   0, 4'b1011, 1, 0, 1);   // frame 0110, en dropped mid-frame
        add(0, 0, 0, 0, 0,   0, 4'b1011, 1, 0, 1);
        add(0, 0, 1, 0, 0,   0, 4'b1011, 1, 0, 1);
        add(0, 0, 1, 0, 0,   0, 4'b1011, 1, 0, 1);
        add(0, 0, 0, 0, 0,   1, 4'b0110, 0, 0, 2);
        add(0, 1, 1, 0, 0,   1, 4'b0110, 1, 0, 2);   // back-to-back 1011, accept on load edge
        add(0, 1, 1, 0, 0,   1, 4'b0110, 1, 0, 2);
        add(0, 1, 0, 0, 0,   1, 4'b0110, 1, 0, 2);
        add(0, 1, 1, 0, 0,   1, 4'b0110, 1, 0, 2);
        add(0, 1, 1, 1, 0,   1, 4'b1011, 0, 0, 3);
        add(0, 1, 1, 0, 0,   1, 4'b1011, 1, 0, 3);   // back-to-back 0110, not accepted
        add(0, 1, 0, 0, 0,   1, 4'b1011, 1, 0, 3);
        add(0, 1, 1, 0, 0,   1, 4'b1011, 1, 0, 3);
        add(0, 1, 1, 0, 0,   1, 4'b1011, 1, 0, 3);
        add(0, 1, 0, 0, 0,   1, 4'b1011, 0, 1, 3);   // overrun
        add(0, 0, 0, 0, 1,   1, 4'b1011, 0, 0, 3);   // clear
        add(0, 1, 1, 0, 0,   1, 4'b1011, 1, 0, 3);   // frame 1001, overrun with clr on same edge
        add(0, 0, 1, 0, 0,   1, 4'b1011, 1, 0, 3);
        add(0, 0, 0, 0, 0,   1, 4'b1011, 1, 0, 3);
        add(0, 0, 0, 0, 0,   1, 4'b1011, 1, 0, 3);
        add(0, 0, 1, 0, 1,   1, 4'b1011, 0, 1, 3);
        add(0, 0, 0, 0, 1,   1, 4'b1011, 0, 0, 3);
        add(0, 0, 0, 1, 0,   0, 4'b1011, 0, 0, 3);
        add(0, 0, 0, 1, 0,   0, 4'b1011, 0, 0, 3);   // ready without valid: no effect

        foreach (tbl[i]) begin
            rst = tbl[i].rst; en = tbl[i].en; sin = tbl[i].sin;
            dout_ready = tbl[i].rdy; clr_flags = tbl[i].clr;
            tick();
            check_all($sformatf("row%0d", i), tbl[i].e_valid, tbl[i].e_dout,
                      tbl[i].e_busy, tbl[i].e_ov, tbl[i].e_cnt);
        end
        check("parity_err tied", 32'(parity_err), 32'(0));
        rst = 1'b1; en = 1'b0; sin = 1'b0; dout_ready = 1'b0; clr_flags = 1'b0;
`endif

        // Reset state
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_all("reset", 1'b0, 4'b0000, 1'b0, 1'b0, 8'd0);
        check("reset parity_err", 32'(parity_err), 32'(0));

        // en low: a high serial line never starts a frame
        en = 1'b0; sin = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check($sformatf("en0 busy%0d", i), 32'(busy), 32'(0));
        end
        check("en0 valid", 32'(dout_valid), 32'(0));
        check("en0 cnt",   32'(word_cnt),   32'(0));

        // en pulsed only for the start bit; frame still completes
        send_frame(4'b1001, 1'b0, 1'b1);
        check_all("en pulse", 1'b1, 4'b1001, 1'b0, 1'b0, 8'd1);

        // Reset after two data bits discards the partial word
        en = 1'b1; sin = 1'b1; dout_ready = 1'b1;
        tick();
        en = 1'b0; sin = 1'b1; tick();
        sin = 1'b1; tick();
        check("pre-rst busy", 32'(busy), 32'(1));
        rst = 1'b1; sin = 1'b0; dout_ready = 1'b0;
        tick();
        rst = 1'b0;
        check_all("mid rst", 1'b0, 4'b0000, 1'b0, 1'b0, 8'd0);
        send_frame(4'b0101, 1'b0, 1'b1);
        check_all("after rst", 1'b1, 4'b0101, 1'b0, 1'b0, 8'd1);

        // word_cnt wrap: 254 more loads reach 255, one more wraps to 0
        for (int i = 0; i < 254; i++) send_frame(4'(i), 1'b1, 1'b1);
        check("cnt 255", 32'(word_cnt), 32'(255));
        send_frame(4'b1110, 1'b1, 1'b1);
        check("cnt wrap", 32'(word_cnt), 32'(0));
        check("wrap dout", 32'(dout), 32'(4'b1110));
        check("wrap ov",   32'(overrun), 32'(0));

`ifdef SIPO_FRAME_CTRL_PARITY_EN
        rst = 1'b1; dout_ready = 1'b0; tick(); rst = 1'b0;
        // Good parity: not loaded at T+4, loaded at T+5
        en = 1'b1; sin = 1'b1; tick(); en = 1'b0;
        sin = 1'b1; tick();
        sin = 1'b0; tick();
        sin = 1'b1; tick();
        sin = 1'b1; tick();
        check("par T+4 valid", 32'(dout_valid), 32'(0));
        check("par T+4 busy",  32'(busy),       32'(1));
        sin = 1'b1; tick();
        check_all("par good", 1'b1, 4'b1011, 1'b0, 1'b0, 8'd1);
        check("par good err", 32'(parity_err), 32'(0));
        sin = 1'b0; dout_ready = 1'b1; tick(); dout_ready = 1'b0;
        // Bad parity: dropped, flag set, counter unchanged
        send_frame(4'b1011, 1'b0, 1'b0);
        check_all("par bad", 1'b0, 4'b1011, 1'b0, 1'b0, 8'd1);
        check("par bad err", 32'(parity_err), 32'(1));
        clr_flags = 1'b1; tick(); clr_flags = 1'b0;
        check("par clr err", 32'(parity_err), 32'(0));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
